// File: rtl/k2_seq_pkg.sv
// Shared types and constants for the k2 fetch sequencer.
//   seq_state_t      : fetch/issue controller state encoding
//   DEFAULT_RESET_PC : program counter value taken on reset unless overridden
package k2_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ISSUE,
    HALTED
  } seq_state_t;

  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register for the k2 fetch sequencer.
//   clk    : system clock
//   reset  : synchronous active-high reset, loads RESET_PC
//   load   : take target (wins over inc)
//   inc    : advance by one, wrapping at 2^ADDR_W
//   target : redirect address
//   pc     : current program counter
module pc_reg
  import k2_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = target;
    end else if (inc) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/issue controller for the k2 core. Owns the PC, issues one
// instruction-memory read per instruction, presents the captured word to decode
// with a valid/ready handshake, applies branch redirects and halt, and counts
// retired instructions.
//   clk, reset            : clock, synchronous active-high reset
//   run                   : start/resume; only its rising edge matters
//   imem_req/imem_addr    : one-cycle read strobe and address (= pc)
//   imem_valid/imem_data  : read response, looked at only while waiting for it
//   instr/instr_valid     : captured instruction and its valid
//   instr_ready           : decode accepts
//   branch_taken/_target  : redirect, used only on the handshake cycle
//   halt                  : stop after this instruction, handshake cycle only
//   pc, halted            : current PC and halted indication
//   retire_count          : completed handshakes, wrapping
module fetch_sequencer
  import k2_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       INSTR_W  = 8,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_count
);

  seq_state_t         state_q, state_d;
  logic               run_q;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   retire_q, retire_d;
  logic               pc_load, pc_inc;
  logic               run_rise;

  assign run_rise = run & ~run_q;

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (branch_target),
    .pc     (pc)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    retire_d = retire_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_rise) state_d = FETCH;
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          instr_d = imem_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          retire_d = retire_q + CNT_W'(1);
          // Halt still advances past the retiring instruction and beats a redirect.
          if (halt) begin
            pc_inc  = 1'b1;
            state_d = HALTED;
          end else if (branch_taken) begin
            pc_load = 1'b1;
            state_d = FETCH;
          end else begin
            pc_inc  = 1'b1;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        // Edge-only restart: a run level left high across the halt is ignored.
        if (run_rise) state_d = FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      instr_q  <= '0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= run;
      instr_q  <= instr_d;
      retire_q <= retire_d;
    end
  end

  assign imem_req     = (state_q == FETCH);
  assign instr_valid  = (state_q == ISSUE);
  assign halted       = (state_q == HALTED);
  assign imem_addr    = pc;
  assign instr        = instr_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic.
// A memory responder answers each read after a set latency; a reference model
// predicts fetch addresses, issued instructions, PC, halt and retire count, and
// a monitor on the falling edge compares them with the DUT every cycle.
module tb_fetch_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_valid;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       branch_taken;
  logic [3:0] branch_target;
  logic       halt;
  logic [3:0] pc;
  logic       halted;
  logic [15:0] retire_count;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .pc            (pc),
    .halted        (halted),
    .retire_count  (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string nm, input int unsigned act, input int unsigned req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_total++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Instruction memory contents, shared by the responder and the model.
  logic [7:0] mem [16];
  int         lat = 2;  // 0 selects a random latency of 1..3 per read

  // Memory responder
  logic       pend = 1'b0;
  int         cd = 0;
  logic [3:0] raddr = '0;

  always @(posedge clk) begin
    #1;
    if (pend) begin
      cd--;
      if (cd == 0) begin
        imem_valid = 1'b1;
        imem_data  = mem[raddr];
        pend       = 1'b0;
      end else begin
        imem_valid = 1'b0;
        imem_data  = 8'($urandom);
      end
    end else if (imem_req) begin
      pend       = 1'b1;
      cd         = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
      raddr      = imem_addr;
      imem_valid = ($urandom % 4 == 0);
      imem_data  = 8'($urandom);
    end else begin
      // Stray responses outside a pending read must be ignored by the DUT.
      imem_valid = ($urandom % 8 == 0);
      imem_data  = 8'($urandom);
    end
  end

  // Reference model + scoreboard
  logic        armed = 1'b0;
  logic        exp_req = 1'b0, waiting = 1'b0, exp_issue = 1'b0;
  logic        exp_idle = 1'b1, exp_halted = 1'b0, prev_run = 1'b0;
  logic [3:0]  exp_pc = '0;
  logic [15:0] exp_cnt = '0;
  logic [3:0]  fetch_q [$];
  logic [7:0]  instr_q [$];
  int          hs_cnt = 0;

  always @(negedge clk) begin
    logic       nreq;
    logic [3:0] a;
    if (armed) begin
      check("imem_req", 32'(imem_req), 32'(exp_req));
      if (imem_req) begin
        if (fetch_q.size() == 0) begin
          timeout("unexpected_fetch");
        end else begin
          a = fetch_q.pop_front();
          check("imem_addr", 32'(imem_addr), 32'(a));
        end
      end
      check("instr_valid", 32'(instr_valid), 32'(exp_issue));
      if (instr_valid && instr_q.size() > 0) check("instr", 32'(instr), 32'(instr_q[0]));
      check("pc", 32'(pc), 32'(exp_pc));
      check("halted", 32'(halted), 32'(exp_halted));
      check("retire_count", 32'(retire_count), 32'(exp_cnt));
    end
    if (reset) begin
      armed      = 1'b1;
      exp_req    = 1'b0;
      waiting    = 1'b0;
      exp_issue  = 1'b0;
      exp_idle   = 1'b1;
      exp_halted = 1'b0;
      prev_run   = 1'b0;
      exp_pc     = '0;
      exp_cnt    = '0;
      fetch_q.delete();
      instr_q.delete();
    end else if (armed) begin
      nreq = 1'b0;
      if (exp_req) begin
        waiting = 1'b1;
      end else if (waiting && imem_valid) begin
        waiting   = 1'b0;
        exp_issue = 1'b1;
        instr_q.push_back(mem[exp_pc]);
      end else if (exp_issue && instr_ready) begin
        exp_issue = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        hs_cnt++;
        void'(instr_q.pop_front());
        if (halt) begin
          exp_pc     = exp_pc + 4'd1;
          exp_halted = 1'b1;
        end else begin
          exp_pc = branch_taken ? branch_target : exp_pc + 4'd1;
          nreq   = 1'b1;
        end
      end else if ((exp_idle || exp_halted) && run && !prev_run) begin
        exp_idle   = 1'b0;
        exp_halted = 1'b0;
        nreq       = 1'b1;
      end
      if (nreq) fetch_q.push_back(exp_pc);
      exp_req  = nreq;
      prev_run = run;
    end
  end

  // Stimulus helpers: inputs change only at posedge + 1.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) timeout(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic br, input logic [3:0] tgt, input logic hl);
    instr_ready   = 1'b1;
    branch_taken  = br;
    branch_target = tgt;
    halt          = hl;
    cyc(1);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    halt         = 1'b0;
  endtask

  initial begin
    int n;
    int quiet;
    reset = 1'b1; run = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    branch_target = '0; halt = 1'b0; imem_valid = 1'b0; imem_data = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

    cyc(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_pc", 32'(pc), 0);
    check("rst_retire", 32'(retire_count), 0);
    check("rst_instr", 32'(instr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_req", 32'(imem_req), 0);

    // Straight-line fetch of 0..3 with latency 2.
    cyc(1);
    instr_ready = 1'b1;
    run = 1'b1;
    cyc(1);
    run = 1'b0;
    n = 0;
    @(negedge clk);
    while (retire_count != 16'd4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (retire_count != 16'd4) timeout("straight_line");
    check("straight_pc", 32'(pc), 4);
    check("straight_instr", 32'(instr), 32'h00A3);
    cyc(1);
    instr_ready = 1'b0;

    // Backpressure with a branch request visible during the stall.
    wait_valid("issue_pc4");
    branch_taken  = 1'b1;
    branch_target = 4'd9;
    cyc(5);
    handshake(1'b1, 4'd9, 1'b0);
    @(negedge clk);
    check("branch_pc", 32'(pc), 9);
    check("branch_retire", 32'(retire_count), 5);

    // Wrap from 15 to 0.
    wait_valid("issue_pc9");
    handshake(1'b1, 4'd15, 1'b0);
    wait_valid("issue_pc15");
    handshake(1'b0, 4'd0, 1'b0);
    @(negedge clk);
    check("wrap_pc", 32'(pc), 0);

    // Halt beats branch; run held across the halt does not restart.
    wait_valid("issue_pc0");
    handshake(1'b1, 4'd5, 1'b0);
    wait_valid("issue_pc5");
    run = 1'b1;
    cyc(1);
    handshake(1'b1, 4'd2, 1'b1);
    @(negedge clk);
    check("halt_flag", 32'(halted), 1);
    check("halt_pc", 32'(pc), 6);
    cyc(10);
    @(negedge clk);
    check("halt_hold", 32'(halted), 1);
    cyc(1);
    run = 1'b0;
    cyc(1);
    run = 1'b1;
    n = 0;
    @(negedge clk);
    while (!imem_req && n < 5) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) timeout("resume_fetch");
    check("resume_addr", 32'(imem_addr), 6);

    // Reset one cycle after the request; the response lands in IDLE.
    @(posedge clk);
    #1;
    reset = 1'b1;
    run   = 1'b0;
    cyc(1);
    reset = 1'b0;
    @(negedge clk);
    check("midwait_pc", 32'(pc), 0);
    check("midwait_retire", 32'(retire_count), 0);
    check("midwait_valid", 32'(instr_valid), 0);
    check("midwait_halted", 32'(halted), 0);
    cyc(6);

    // Random traffic.
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    lat   = 0;
    quiet = 0;
    for (int c = 0; c < 2000; c++) begin
      if (quiet > 0) begin
        quiet--;
        reset = 1'b0;
        run   = 1'b0;
      end else if ($urandom % 250 == 0) begin
        reset = 1'b1;
        run   = 1'b0;
        quiet = 5;
      end else begin
        reset = 1'b0;
        run   = ($urandom % 3 == 0);
      end
      instr_ready   = ($urandom % 5 < 3);
      branch_taken  = ($urandom % 3 == 0);
      branch_target = 4'($urandom);
      halt          = ($urandom % 12 == 0);
      cyc(1);
    end

    // Drain: stop any in-flight instruction with halt.
    reset = 1'b0; run = 1'b0; branch_taken = 1'b0;
    halt = 1'b1; instr_ready = 1'b1;
    cyc(20);
    @(negedge clk);
    check("fetch_queue_drained", 32'(fetch_q.size()), 0);
    check("instr_queue_drained", 32'(instr_q.size()), 0);
    check("random_progress", 32'(hs_cnt > 100), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
